// File: rtl/regfile_access_ctrl_pkg.sv
// regfile_access_ctrl_pkg: shared encodings for the register file access controller
package regfile_access_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [5:0] RF_OP_RTYPE = 6'd0;
  localparam logic [5:0] RF_OP_ITYPE = 6'd8;
  localparam logic [5:0] RF_OP_NOP = 6'd2;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RSP  = 2'd3
  } state_t;
endpackage

// File: rtl/regfile_access_ctrl_arbiter.sv
// rf_arbiter: write-priority grant with a streak counter that forces a pending read through
module rf_arbiter #(
  parameter int MAX_WB_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic busy_i,
  input  logic rd_valid_i,
  input  logic wb_valid_i,
  output logic rd_grant_o,
  output logic wb_grant_o
);
  localparam logic [3:0] MAX_S = 4'(MAX_WB_STREAK);
  logic [3:0] streak_q, streak_d;
  logic force_rd;
  // Grant decision and next streak value; the streak only counts writes that overtake a waiting read
  always_comb begin
    force_rd = rd_valid_i && streak_q == MAX_S;
    wb_grant_o = !busy_i && wb_valid_i && !force_rd;
    rd_grant_o = !busy_i && rd_valid_i && (!wb_valid_i || force_rd);
    streak_d = (!rd_valid_i || rd_grant_o) ? '0 :
               (wb_grant_o && streak_q != MAX_S) ? streak_q + 4'd1 : streak_q;
  end
  // Streak register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) streak_q <= '0;
    else streak_q <= streak_d;
  end
endmodule

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: arbitrates read/write-back requests onto a one-op-per-cycle register file
// Optional: REGFILE_ZERO_REG_EN makes register 0 read as zero and drops writes to it.
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int MAX_WB_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic                  rd_req_two,
  input  logic [REG_ADDR_W-1:0] rd_req_rs,
  input  logic [REG_ADDR_W-1:0] rd_req_rt,
  output logic                  rd_rsp_valid,
  output logic [WORD_SIZE-1:0]  rd_rsp_data1,
  output logic [WORD_SIZE-1:0]  rd_rsp_data2,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [WORD_SIZE-1:0]  wb_data,
  output logic [5:0]            rf_opcode,
  output logic                  rf_regwrite,
  output logic [REG_ADDR_W-1:0] rf_readreg1,
  output logic [REG_ADDR_W-1:0] rf_readreg2,
  output logic [REG_ADDR_W-1:0] rf_writereg,
  output logic [WORD_SIZE-1:0]  rf_writedata,
  input  logic [WORD_SIZE-1:0]  rf_readdata1,
  input  logic [WORD_SIZE-1:0]  rf_readdata2
);
  state_t state_q, state_d;
  logic two_q, rd_grant, wb_grant, wr_issue, rs_zero, rt_zero;
  rf_arbiter #(.MAX_WB_STREAK(MAX_WB_STREAK)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .busy_i     (state_q == RD),
    .rd_valid_i (rd_req_valid),
    .wb_valid_i (wb_valid),
    .rd_grant_o (rd_grant),
    .wb_grant_o (wb_grant)
  );
  assign rd_req_ready = rd_grant;
  assign wb_ready = wb_grant;
`ifdef REGFILE_ZERO_REG_EN
  assign wr_issue = wb_grant && wb_addr != '0;
  assign rs_zero = rf_readreg1 == '0;
  assign rt_zero = rf_readreg2 == '0;
`else
  assign wr_issue = wb_grant;
  assign rs_zero = 1'b0;
  assign rt_zero = 1'b0;
`endif
  // Regfile read data is registered at the end of RD, so it is simply passed through in RSP
  assign rd_rsp_data1 = rs_zero ? '0 : rf_readdata1;
  assign rd_rsp_data2 = (!two_q || rt_zero) ? '0 : rf_readdata2;
  // Next state: RD always resolves to RSP, otherwise follow the grant
  always_comb begin
    state_d = state_q == RD ? RSP : wr_issue ? WR : rd_grant ? RD : IDLE;
  end
  // FSM with registered regfile controls; address/data fields hold until the next grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      two_q <= 1'b0;
      rd_rsp_valid <= 1'b0;
      rf_opcode <= RF_OP_NOP;
      rf_regwrite <= 1'b0;
      rf_readreg1 <= '0;
      rf_readreg2 <= '0;
      rf_writereg <= '0;
      rf_writedata <= '0;
    end else begin
      state_q <= state_d;
      rd_rsp_valid <= state_d == RSP;
      rf_regwrite <= wr_issue;
      rf_opcode <= wr_issue ? RF_OP_RTYPE : rd_grant ? (rd_req_two ? RF_OP_RTYPE : RF_OP_ITYPE) : RF_OP_NOP;
      if (wr_issue) begin
        rf_writereg <= wb_addr;
        rf_writedata <= wb_data;
      end
      if (rd_grant) begin
        rf_readreg1 <= rd_req_rs;
        rf_readreg2 <= rd_req_rt;
        two_q <= rd_req_two;
      end
    end
  end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: scoreboard bench for regfile_access_ctrl with a behavioural register file
module tb_regfile_access_ctrl;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    int c;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_req_valid = 1'b0, rd_req_ready, rd_req_two = 1'b0;
  logic [4:0] rd_req_rs = '0, rd_req_rt = '0;
  logic rd_rsp_valid;
  logic [31:0] rd_rsp_data1, rd_rsp_data2;
  logic wb_valid = 1'b0, wb_ready;
  logic [4:0] wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [5:0] rf_opcode;
  logic rf_regwrite;
  logic [4:0] rf_readreg1, rf_readreg2, rf_writereg;
  logic [31:0] rf_writedata;
  logic [31:0] rf_readdata1 = '0, rf_readdata2 = '0;
  logic [31:0] mem [32] = '{default: 32'd0};
  exp_t exp_q[$];
  int total = 0, bad = 0, cyc = 0, rsp_cnt = 0, w_cyc = 0, r_cyc = 0;

  regfile_access_ctrl dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_two(rd_req_two),
    .rd_req_rs(rd_req_rs), .rd_req_rt(rd_req_rt),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data1(rd_rsp_data1), .rd_rsp_data2(rd_rsp_data2),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_opcode(rf_opcode), .rf_regwrite(rf_regwrite),
    .rf_readreg1(rf_readreg1), .rf_readreg2(rf_readreg2), .rf_writereg(rf_writereg),
    .rf_writedata(rf_writedata), .rf_readdata1(rf_readdata1), .rf_readdata2(rf_readdata2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rf_opcode != 6'd2) begin
      if (rf_regwrite) mem[rf_writereg] <= rf_writedata;
      else begin
        rf_readdata1 <= mem[rf_readreg1];
        rf_readdata2 <= mem[rf_readreg2];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rd_rsp_valid) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got data1=%h data2=%h expected no response", rd_rsp_data1, rd_rsp_data2);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_data1", rd_rsp_data1, e.d1);
        check("rsp_data2", rd_rsp_data2, e.d2);
        check("rsp_latency", 32'(cyc), 32'(e.c));
      end
    end
  end

  task automatic issue(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rv, input logic two, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] e1, input logic [31:0] e2);
    logic wacc, racc;
    logic exp_wr;
    exp_wr = !(ZR && wa == 5'd0);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    rd_req_valid = rv; rd_req_two = two; rd_req_rs = rs; rd_req_rt = rt;
    for (int n = 0; n < 20 && (wb_valid || rd_req_valid); n++) begin
      #1;
      wacc = wb_valid && wb_ready;
      racc = rd_req_valid && rd_req_ready;
      check("ready_exclusive", 32'(wb_ready && rd_req_ready), 32'd0);
      if (racc) exp_q.push_back('{d1: e1, d2: e2, c: cyc + 2});
      @(negedge clk);
      if (wacc) begin
        wb_valid = 1'b0;
        w_cyc = cyc;
        check("wr_regwrite", 32'(rf_regwrite), 32'(exp_wr));
        if (exp_wr) begin
          check("wr_opcode", 32'(rf_opcode), 32'd0);
          check("wr_writereg", 32'(rf_writereg), 32'(wa));
          check("wr_writedata", rf_writedata, wd);
        end
      end
      if (racc) begin
        rd_req_valid = 1'b0;
        r_cyc = cyc;
        check("rd_opcode", 32'(rf_opcode), two ? 32'd0 : 32'd8);
        check("rd_regwrite", 32'(rf_regwrite), 32'd0);
        check("rd_readreg1", 32'(rf_readreg1), 32'(rs));
      end
    end
    if (wb_valid || rd_req_valid) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got wb_valid=%0b rd_valid=%0b still pending expected accepted", wb_valid, rd_req_valid);
      wb_valid = 1'b0;
      rd_req_valid = 1'b0;
    end
  endtask

  initial begin
    int g, eg, base;
    repeat (1) @(negedge clk);
    check("rst_opcode", 32'(rf_opcode), 32'd2);
    check("rst_regwrite", 32'(rf_regwrite), 32'd0);
    check("rst_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    check("rst_writedata", rf_writedata, 32'd0);
    check("rst_wb_ready", 32'(wb_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
    issue(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0);
    issue(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd5, 5'd5, 32'hDEADBEEF, 32'd0);
    issue(1'b1, 5'd7, 32'h1234, 1'b1, 1'b0, 5'd7, 5'd3, 32'h1234, 32'd0);
    check("raw_write_first", 32'(w_cyc < r_cyc), 32'd1);
    repeat (3) @(negedge clk);
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5A5A5A5;
    rd_req_valid = 1'b1; rd_req_two = 1'b1; rd_req_rs = 5'd9; rd_req_rt = 5'd5;
    for (int i = 0; i < 18; i++) begin
      #1;
      g = wb_ready ? 1 : rd_req_ready ? 2 : 0;
      eg = (i % 6 < 4) ? 1 : (i % 6 == 4) ? 2 : 0;
      check("ready_exclusive", 32'(wb_ready && rd_req_ready), 32'd0);
      check("starve_grant", 32'(g), 32'(eg));
      if (rd_req_ready) exp_q.push_back('{d1: 32'hA5A5A5A5, d2: 32'hDEADBEEF, c: cyc + 2});
      @(negedge clk);
    end
    wb_valid = 1'b0;
    rd_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rd_req_valid = 1'b1; rd_req_two = 1'b1; rd_req_rs = 5'd5; rd_req_rt = 5'd7;
    #1;
    check("rst_rd_accept", 32'(rd_req_ready), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    rd_req_valid = 1'b0;
    #1;
    check("midrd_opcode", 32'(rf_opcode), 32'd2);
    check("midrd_regwrite", 32'(rf_regwrite), 32'd0);
    check("midrd_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    check("midrd_readreg1", 32'(rf_readreg1), 32'd0);
    check("midrd_readreg2", 32'(rf_readreg2), 32'd0);
    check("midrd_writereg", 32'(rf_writereg), 32'd0);
    base = rsp_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("no_rsp_after_rst", 32'(rsp_cnt), 32'(base));
    issue(1'b1, 5'd0, 32'h0000FFFF, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
    issue(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd0, 5'd0, ZR ? 32'd0 : 32'h0000FFFF, ZR ? 32'd0 : 32'h0000FFFF);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Sequencing and arbitration controller in front of the synchronous register file (ports opcode/Regwrite/ReadReg1/ReadReg2/WriteReg/WriteData/ReadData1/ReadData2).
- The register file performs either one write or one read per clock, selected by Regwrite.
- Arbitrates between an operand-read requester (decode) and a write-back requester, drives the register file control inputs, and returns read data with a valid pulse.
- Write-back has priority; a starvation guard guarantees read progress.

Parameters:
- WORD_SIZE, 32, datapath width; must match the `WORD_SIZE` macro used by the register file.
- MAX_WB_STREAK, 4, max consecutive write grants while a read is pending before the read is forced through; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- rd_req_valid  in  1  operand-read request
- rd_req_ready  out  1  read request accepted when valid&ready at posedge
- rd_req_two  in  1  1 = two-source (R-type) read, 0 = single-source (I-type) read
- rd_req_rs  in  5  first source register
- rd_req_rt  in  5  second source register (ignored when rd_req_two=0)
- rd_rsp_valid  out  1  one-cycle pulse, read data valid; no backpressure
- rd_rsp_data1  out  WORD_SIZE  source 1 value
- rd_rsp_data2  out  WORD_SIZE  source 2 value (0 for single-source)
- wb_valid  in  1  write-back request
- wb_ready  out  1  write accepted when valid&ready at posedge
- wb_addr  in  5  destination register
- wb_data  in  WORD_SIZE  write data
- rf_opcode  out  6  to regfile opcode
- rf_regwrite  out  1  to regfile Regwrite
- rf_readreg1, rf_readreg2, rf_writereg  out  5 each  to regfile
- rf_writedata  out  WORD_SIZE  to regfile WriteData
- rf_readdata1, rf_readdata2  in  WORD_SIZE  from regfile ReadData1/2

Behaviour:
- FSM states: IDLE, WR, RD, RSP. All rf_* outputs are registered and decoded from state plus captured request fields.
- Reset (async, rst=1):
  - state=IDLE, streak=0, captured fields=0.
  - rd_rsp_valid=0, rf_regwrite=0, rf_opcode=6'd2 (J-type: regfile no-op), all rf addresses and data=0.
- Idle drive: IDLE and RSP drive rf_opcode=6'd2, rf_regwrite=0.
- WR state: rf_opcode=0, rf_regwrite=1, rf_writereg/rf_writedata = captured request. The regfile commits at the edge ending WR.
- RD state: rf_regwrite=0; rf_opcode=0 if two-source, 6'd8 if single-source; rf_readreg1/2 = captured rs/rt.
- RSP state: rd_rsp_valid=1, rd_rsp_data1/2 = rf_readdata1/2 passed through combinationally. rd_rsp_data are don't-care outside RSP.
- Latency and throughput:
  - Read: acceptance edge E0 -> RD -> RSP in the second cycle after E0.
  - Write: accepted at E0, committed at E1.
  - Back-to-back writes every cycle; reads every 2 cycles.
- Ready rules:
  - rd_req_ready = wb_ready = (state != RD) and arbitration grant for that requester. At most one grant per cycle.
  - Next state follows the grant; IDLE if no grant.
- Arbitration:
  - Write wins when both are valid, unless streak == MAX_WB_STREAK, in which case the read wins.
  - streak increments on a write grant while rd_req_valid=1, saturating at MAX_WB_STREAK.
  - streak clears on a read grant or whenever rd_req_valid=0.
- RAW ordering: a write granted before a read to the same register is always visible to that read (WR commits before RD samples). No bypass.
- Requests not granted must be held stable by the requester until accepted.
- Reset mid-read (in RD): the read is dropped, no rd_rsp_valid pulse, and the requester re-issues.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - Writes with wb_addr=0 are accepted (wb_ready=1) but not issued: state stays or returns to IDLE, no WR cycle.
  - Reads return 0 for any source equal to register 0, masked in RSP.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Shared package/header:
  - state encoding localparams.
  - RF_OP_RTYPE=6'd0, RF_OP_ITYPE=6'd8, RF_OP_NOP=6'd2.
  - REG_ADDR_W=5.
- Sub-module: rf_arbiter, the combinational grant plus streak counter. The FSM stays in the top module.

Test Plan:
- Reset mid-read: rst pulse while in RD -> all outputs at reset values, rf_opcode=2, no rd_rsp_valid pulse afterwards.
- Write then read: wb write r5=0xDEADBEEF, then two-source read rs=5, rt=0 -> rd_rsp_valid two cycles after read acceptance, data1=0xDEADBEEF, data2=regfile r0.
- Single-source read: single read rs=5 -> rf_opcode=8 during RD, rd_rsp_data2=0.
- Starvation guard: wb_valid and rd_req_valid held high continuously -> exactly 4 write grants, then 1 read grant, then the pattern repeats. Check wb_ready and rd_req_ready are never high together.
- Same-cycle RAW: both requests arrive with write r7=0x1234 and read rs=7 -> write granted first, read returns 0x1234.
- REGFILE_ZERO_REG_EN defined: write r0=0xFFFF -> wb_ready=1, rf_regwrite stays 0; a subsequent read of r0 returns 0.
